// File: rtl/baopoco_quant2_requant.sv
// baopoco_quant2_requant
// Second-stage requantizer for the BAO/poco F-engine. Each complex DIN_W-bit
// sample is scaled by a UFix_16_10 gain, rounded half-up, and saturated
// symmetrically to Fix_4_3 (-7..+7). Output is packed as {re[3:0], im[3:0]}.
// The gain is double-buffered and only changes on a spectrum sync. A clip
// counter reports the number of clipped valid samples in the previous
// spectrum.
//
// Optional feature macro: BAOPOCO_QUANT2_OVF_CNT_EN
//   defined   : clip counter, ovf_count and ovf_strobe are active
//   undefined : ovf_count and ovf_strobe are tied to zero
//
// Ports
//   user_clk   in   sole clock, rising edge
//   user_rst   in   synchronous active-high reset
//   gain_in    in   [31:0] gain word, [15:0] UFix_16_10, [31:16] ignored
//   sync_in    in   spectrum boundary, aligned with the first sample
//   din_valid  in   input sample qualifier
//   din_re     in   [DIN_W-1:0] real component, two's complement
//   din_im     in   [DIN_W-1:0] imaginary component, two's complement
//   sync_out   out  sync_in delayed by 4 cycles
//   dout_valid out  din_valid delayed by 4 cycles
//   dout       out  [7:0] {re, im}, each Fix_4_3
//   ovf_count  out  [CNT_W-1:0] clipped samples in the previous spectrum
//   ovf_strobe out  one-cycle pulse when ovf_count updates
//
// Pipeline (inputs at edge n appear after edge n+4):
//   S1 input register + gain select, S2 multiply (operand and product ranks),
//   S3 round, S4 saturate/pack/count.

module baopoco_quant2_requant #(
    parameter int unsigned DIN_W     = 18,
    parameter int unsigned CNT_W     = 16,
    parameter logic [15:0] GAIN_INIT = 16'h0400
) (
    input  logic             user_clk,
    input  logic             user_rst,
    input  logic [31:0]      gain_in,
    input  logic             sync_in,
    input  logic             din_valid,
    input  logic [DIN_W-1:0] din_re,
    input  logic [DIN_W-1:0] din_im,
    output logic             sync_out,
    output logic             dout_valid,
    output logic [7:0]       dout,
    output logic [CNT_W-1:0] ovf_count,
    output logic             ovf_strobe
);

    localparam int unsigned GW = 16;
    localparam int unsigned PW = DIN_W + 17;
    localparam int unsigned SH = (DIN_W - 1) + 10 - 3;
    localparam int unsigned RW = PW - SH;

    localparam logic signed [PW-1:0] RND   = $signed(PW'(1) << (SH - 1));
    localparam logic signed [RW-1:0] P7    = RW'(7);
    localparam logic signed [RW-1:0] N7    = -P7;

    // S1 registers
    logic [GW-1:0]           r_gain_active;
    logic signed [DIN_W-1:0] r_re1;
    logic signed [DIN_W-1:0] r_im1;
    // S2 registers (multiplier operand rank then product rank)
    logic signed [PW-1:0]    r_pre_m;
    logic signed [PW-1:0]    r_pim_m;
    logic signed [PW-1:0]    r_pre_p;
    logic signed [PW-1:0]    r_pim_p;
    // S3 registers
    logic signed [RW-1:0]    r_rre;
    logic signed [RW-1:0]    r_rim;
    // valid/sync delay line, index 3 is aligned with the S4 input
    logic [3:0]              r_vld;
    logic [3:0]              r_syn;
    // S4 registers
    logic [7:0]              r_dout;
    logic                    r_dout_valid;
    logic                    r_sync_out;

    logic [GW-1:0]           w_gain_sel;
    logic signed [PW-1:0]    w_re_x;
    logic signed [PW-1:0]    w_im_x;
    logic signed [PW-1:0]    w_g_x;
    logic signed [PW-1:0]    w_sre;
    logic signed [PW-1:0]    w_sim;
    logic                    w_re_hi;
    logic                    w_re_lo;
    logic                    w_im_hi;
    logic                    w_im_lo;
    logic [3:0]              w_re_n;
    logic [3:0]              w_im_n;

    // The sync-cycle sample already uses the incoming gain. Since the active
    // gain always loads the selected value, it equals the gain of the sample
    // held in S1 and feeds the multiplier directly.
    assign w_gain_sel = sync_in ? GW'(gain_in) : r_gain_active;

    // Signed sample times unsigned gain, both widened to the product width
    assign w_re_x = PW'(r_re1);
    assign w_im_x = PW'(r_im1);
    assign w_g_x  = $signed(PW'(r_gain_active));

    // Round half-up before the arithmetic shift
    assign w_sre = r_pre_p + RND;
    assign w_sim = r_pim_p + RND;

    // Symmetric saturation: -8 is never produced
    always_comb begin
        w_re_hi = (r_rre > P7);
        w_re_lo = (r_rre < N7);
        w_im_hi = (r_rim > P7);
        w_im_lo = (r_rim < N7);
        w_re_n  = w_re_hi ? 4'h7 : (w_re_lo ? 4'h9 : r_rre[3:0]);
        w_im_n  = w_im_hi ? 4'h7 : (w_im_lo ? 4'h9 : r_rim[3:0]);
    end

    // Data path and control delay line
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_gain_active <= GAIN_INIT;
            r_re1         <= '0;
            r_im1         <= '0;
            r_pre_m       <= '0;
            r_pim_m       <= '0;
            r_pre_p       <= '0;
            r_pim_p       <= '0;
            r_rre         <= '0;
            r_rim         <= '0;
            r_vld         <= '0;
            r_syn         <= '0;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_sync_out    <= 1'b0;
        end else begin
            r_gain_active <= w_gain_sel;
            r_re1         <= din_re;
            r_im1         <= din_im;
            r_pre_m       <= w_re_x * w_g_x;
            r_pim_m       <= w_im_x * w_g_x;
            r_pre_p       <= r_pre_m;
            r_pim_p       <= r_pim_m;
            r_rre         <= RW'(w_sre >>> SH);
            r_rim         <= RW'(w_sim >>> SH);
            r_vld         <= {r_vld[2:0], din_valid};
            r_syn         <= {r_syn[2:0], sync_in};
            r_dout        <= {w_re_n, w_im_n};
            r_dout_valid  <= r_vld[3];
            r_sync_out    <= r_syn[3];
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign sync_out   = r_sync_out;

`ifdef BAOPOCO_QUANT2_OVF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_run;
    logic [CNT_W-1:0] r_ovf_count;
    logic             r_ovf_strobe;
    logic             w_clip;

    assign w_clip = r_vld[3] & (w_re_hi | w_re_lo | w_im_hi | w_im_lo);

    // Per-spectrum clip count; the sync-cycle sample belongs to the new spectrum
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_run        <= '0;
            r_ovf_count  <= '0;
            r_ovf_strobe <= 1'b0;
        end else begin
            r_ovf_strobe <= r_syn[3];
            if (r_syn[3]) begin
                r_ovf_count <= r_run;
                r_run       <= CNT_W'(w_clip);
            end else if (w_clip && (r_run != CNT_MAX)) begin
                r_run <= r_run + CNT_W'(1);
            end
        end
    end

    assign ovf_count  = r_ovf_count;
    assign ovf_strobe = r_ovf_strobe;
`else
    assign ovf_count  = CNT_W'(0);
    assign ovf_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_baopoco_quant2_requant.sv
// Self-checking bench for baopoco_quant2_requant: directed vector table,
// hand-written multi-cycle sequences, and randomized traffic compared every
// cycle against a behavioural model.

module tb_baopoco_quant2_requant;

    localparam int unsigned DIN_W = 18;
    localparam int unsigned CNT_W = 16;
    localparam int          SH    = 24;
    localparam longint      CMAX  = 65535;
`ifdef BAOPOCO_QUANT2_OVF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             user_clk = 1'b0;
    logic             user_rst;
    logic [31:0]      gain_in;
    logic             sync_in;
    logic             din_valid;
    logic [DIN_W-1:0] din_re;
    logic [DIN_W-1:0] din_im;
    logic             sync_out;
    logic             dout_valid;
    logic [7:0]       dout;
    logic [CNT_W-1:0] ovf_count;
    logic             ovf_strobe;

    always #5 user_clk = ~user_clk;

    baopoco_quant2_requant #(
        .DIN_W    (DIN_W),
        .CNT_W    (CNT_W),
        .GAIN_INIT(16'h0400)
    ) dut (
        .user_clk  (user_clk),
        .user_rst  (user_rst),
        .gain_in   (gain_in),
        .sync_in   (sync_in),
        .din_valid (din_valid),
        .din_re    (din_re),
        .din_im    (din_im),
        .sync_out  (sync_out),
        .dout_valid(dout_valid),
        .dout      (dout),
        .ovf_count (ovf_count),
        .ovf_strobe(ovf_strobe)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    // Real-number view: out = round_half_up(x * g / 2^24), clamped to +-7.
    function automatic longint requant(input logic [17:0] x, input logic [15:0] g);
        longint p;
        longint q;
        p = longint'($signed(x)) * longint'(g);
        q = (p + (longint'(1) << (SH - 1))) >>> SH;
        return q;
    endfunction

    function automatic longint clamp7(input longint v);
        if (v > 7)  return 7;
        if (v < -7) return -7;
        return v;
    endfunction

    typedef struct {
        logic       v;
        logic       s;
        logic [7:0] d;
        logic       c;
    } item_t;

    item_t      mq[$];
    logic [15:0] m_gain;
    longint     m_run;
    logic       e_valid, e_sync, e_stb;
    logic [7:0] e_dout;
    longint     e_cnt;

    always @(posedge user_clk) begin
        item_t      it;
        item_t      nw;
        logic [15:0] gs;
        longint     r, i;
        if (user_rst) begin
            mq = {};
            for (int k = 0; k < 4; k++) mq.push_back('{default: '0});
            m_gain  = 16'h0400;
            m_run   = 0;
            e_valid = 1'b0;
            e_sync  = 1'b0;
            e_dout  = 8'h00;
            e_cnt   = 0;
            e_stb   = 1'b0;
        end else begin
            it      = mq.pop_front();
            e_valid = it.v;
            e_sync  = it.s;
            e_dout  = it.d;
            e_stb   = 1'b0;
            if (CNT_EN) begin
                if (it.s) begin
                    e_cnt = m_run;
                    e_stb = 1'b1;
                    m_run = (it.v && it.c) ? 1 : 0;
                end else if (it.v && it.c && m_run < CMAX) begin
                    m_run = m_run + 1;
                end
            end
            gs = sync_in ? gain_in[15:0] : m_gain;
            if (sync_in) m_gain = gain_in[15:0];
            r    = requant(din_re, gs);
            i    = requant(din_im, gs);
            nw.v = din_valid;
            nw.s = sync_in;
            nw.c = (clamp7(r) != r) || (clamp7(i) != i);
            nw.d = {4'(clamp7(r)), 4'(clamp7(i))};
            mq.push_back(nw);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge user_clk) begin
        if (mon_en) begin
            chk("mon_valid", dout_valid, e_valid);
            chk("mon_sync", sync_out, e_sync);
            if (e_valid) chk("mon_dout", dout, e_dout);
            chk("mon_ovf_count", ovf_count, e_cnt);
            chk("mon_ovf_strobe", ovf_strobe, e_stb);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic drive(input logic s, input logic v, input logic [15:0] g,
                         input logic [17:0] re, input logic [17:0] im);
        sync_in   = s;
        din_valid = v;
        gain_in   = {16'($urandom), g};
        din_re    = re;
        din_im    = im;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0, 18'h0, 18'h0);
    endtask

    // Wait (bounded) for the next sync_out and check the reported count
    task automatic wait_sync(input string nm, input longint exp_cnt);
        int k;
        k = 0;
        while (!sync_out && k < 40) begin
            tick();
            k++;
        end
        chk({nm, "_sync_seen"}, sync_out, 1);
        chk({nm, "_ovf_count"}, ovf_count, exp_cnt);
        chk({nm, "_ovf_strobe"}, ovf_strobe, CNT_EN);
        tick();
        chk({nm, "_strobe_single"}, ovf_strobe, 0);
    endtask

    typedef struct {
        logic [15:0]        g;
        logic signed [17:0] re;
        logic signed [17:0] im;
        logic [7:0]         d;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int cnt_v, cnt_s;

        tbl[0] = '{16'h0400,  18'sd32768,  -18'sd32768, 8'h2E};
        tbl[1] = '{16'h0400,  18'sd12288,   18'sd0,     8'h10};
        tbl[2] = '{16'h0400,  18'sd8192,    18'sd0,     8'h10};
        tbl[3] = '{16'h0400, -18'sd8192,    18'sd0,     8'h00};
        tbl[4] = '{16'h0400,  18'sd4095,    18'sd0,     8'h00};
        tbl[5] = '{16'h0400,  18'sd0,      -18'sd131072, 8'h09};
        tbl[6] = '{16'hFFFF,  18'sd16384,   18'sd0,     8'h70};
        tbl[7] = '{16'h0400,  18'sd131071, -18'sd16384, 8'h7F};
        tbl[8] = '{16'h0800, -18'sd16384,   18'sd16384, 8'hE2};
        tbl[9] = '{16'h0400, -18'sd24576,  -18'sd40960, 8'hFE};

        user_rst = 1'b1;
        idle();
        tick();
        tick();
        mon_en = 1'b1;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_sync", sync_out, 0);
        chk("rst_ovf_count", ovf_count, 0);
        user_rst = 1'b0;

        // First sample after reset uses GAIN_INIT (no sync)
        drive(1'b0, 1'b1, 16'h1234, 18'sd32768, -18'sd32768);
        tick();
        idle();
        repeat (3) tick();
        chk("lat3_not_yet", dout_valid, 0);
        tick();
        chk("init_gain_valid", dout_valid, 1);
        chk("init_gain_dout", dout, 8'h2E);

        // Vector table: each entry is a sync sample carrying its own gain
        for (int n = 0; n < 10; n++) begin
            drive(1'b1, 1'b1, tbl[n].g, tbl[n].re, tbl[n].im);
            tick();
            idle();
            repeat (4) tick();
            chk($sformatf("vec%0d_valid", n), dout_valid, 1);
            chk($sformatf("vec%0d_dout", n), dout, tbl[n].d);
        end

        // Gain buffering: mid-spectrum write is ignored until sync
        drive(1'b1, 1'b1, 16'h0800, 18'sd16384, 18'sd0);
        tick();
        drive(1'b0, 1'b1, 16'h1000, 18'sd16384, 18'sd0);
        tick();
        drive(1'b1, 1'b1, 16'h1000, 18'sd16384, 18'sd0);
        tick();
        idle();
        repeat (2) tick();
        chk("gbuf_before", dout, 8'h20);
        tick();
        chk("gbuf_midwrite", dout, 8'h20);
        tick();
        chk("gbuf_sync_sample", dout, 8'h40);
        repeat (4) tick();

        // Counter: 5 valid samples, 3 clipped, then an empty spectrum
        drive(1'b1, 1'b1, 16'h0400, 18'sd0, 18'sd0);
        tick();
        drive(1'b0, 1'b1, 16'h0, 18'sd131071, 18'sd0);
        tick();
        drive(1'b0, 1'b1, 16'h0, 18'sd0, 18'sd0);
        tick();
        drive(1'b0, 1'b1, 16'h0, 18'sd0, -18'sd131072);
        tick();
        drive(1'b0, 1'b1, 16'h0, -18'sd131072, 18'sd0);
        tick();
        drive(1'b1, 1'b0, 16'h0400, 18'sd0, 18'sd0);
        tick();
        idle();
        wait_sync("cnt3", CNT_EN ? 3 : 0);
        drive(1'b1, 1'b0, 16'h0400, 18'sd0, 18'sd0);
        tick();
        idle();
        wait_sync("cnt_empty", 0);
        repeat (4) tick();

        // Back-to-back syncs, each sample clipped
        cnt_v = 0;
        cnt_s = 0;
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 1'b1, 16'h0400, 18'sd131071, 18'sd0);
            tick();
        end
        idle();
        for (int n = 0; n < 10; n++) begin
            tick();
            if (ovf_strobe) cnt_v++;
            if (sync_out) cnt_s++;
        end
        chk("b2b_strobes", cnt_v, CNT_EN ? 3 : 0);
        chk("b2b_syncs", cnt_s, 3);

        // Counter saturation: 65540 clipped samples in one spectrum
        for (int n = 0; n < 65540; n++) begin
            drive(n == 0, 1'b1, 16'h0400, 18'sd131071, 18'sd0);
            tick();
        end
        drive(1'b1, 1'b0, 16'h0400, 18'sd0, 18'sd0);
        tick();
        idle();
        wait_sync("cnt_sat", CNT_EN ? CMAX : 0);
        repeat (4) tick();

        // Reset with samples in flight
        drive(1'b1, 1'b1, 16'h0800, 18'sd16384, 18'sd0);
        tick();
        drive(1'b1, 1'b1, 16'h0800, 18'sd16384, 18'sd0);
        tick();
        drive(1'b0, 1'b1, 16'h0800, 18'sd16384, 18'sd0);
        tick();
        idle();
        user_rst = 1'b1;
        tick();
        user_rst = 1'b0;
        cnt_v = 0;
        cnt_s = 0;
        for (int n = 0; n < 6; n++) begin
            if (dout_valid) cnt_v++;
            if (sync_out) cnt_s++;
            tick();
        end
        chk("rst_flush_valid", cnt_v, 0);
        chk("rst_flush_sync", cnt_s, 0);
        drive(1'b0, 1'b1, 16'h0800, 18'sd16384, 18'sd0);
        tick();
        idle();
        repeat (4) tick();
        chk("rst_gain_restored", dout, 8'h10);

        // Randomized traffic checked by the model
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] g;
            g = ($urandom % 8 == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0C00));
            drive(($urandom % 40) == 0, ($urandom % 4) != 0, g,
                  18'($signed(18'($urandom)) >>> ($urandom % 12)),
                  18'($signed(18'($urandom)) >>> ($urandom % 12)));
            user_rst = (($urandom % 700) == 0);
            tick();
        end
        user_rst = 1'b0;
        idle();
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
